// File: rtl/ib_lut_pkg.sv
// Shared defaults and FSM state encoding for the IB-LUT ping/pong reload controller.
package ib_lut_pkg;

    localparam int unsigned DFLT_QUAN_SIZE     = 3;
    localparam int unsigned DFLT_PAGE_NUM      = 32;
    localparam int unsigned DFLT_ADDR_BITWIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

endpackage

// File: rtl/ib_lut_wr_stage.sv
// One-cycle LUTRAM write register: turns an accepted beat into a banked write next cycle.
module ib_lut_wr_stage
    import ib_lut_pkg::*;
#(
    parameter int unsigned QUAN_SIZE     = DFLT_QUAN_SIZE,
    parameter int unsigned ADDR_BITWIDTH = DFLT_ADDR_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid_i,
    input  logic                     wr_bank_i,
    input  logic [ADDR_BITWIDTH-1:0] wr_addr_i,
    input  logic [QUAN_SIZE-1:0]     wr_data_i,
    input  logic                     flush_i,
    output logic [1:0]               we_o,
    output logic [ADDR_BITWIDTH-1:0] waddr_o,
    output logic [QUAN_SIZE-1:0]     wdata_o
);

    logic [1:0]               we_q, we_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [QUAN_SIZE-1:0]     data_q, data_d;

    always_comb begin
        we_d   = '0;
        addr_d = addr_q;
        data_d = data_q;
        if (wr_valid_i && !flush_i) begin
            we_d[wr_bank_i] = 1'b1;
            addr_d          = wr_addr_i;
            data_d          = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = addr_q;
    assign wdata_o = data_q;

endmodule

// File: rtl/ib_lut_pingpong_load_ctrl.sv
// Loads a streamed IB-LUT page set into the shadow bank and swaps banks at the
// decoder's iteration boundary once the shadow set is complete.
module ib_lut_pingpong_load_ctrl
    import ib_lut_pkg::*;
#(
    parameter int unsigned QUAN_SIZE     = DFLT_QUAN_SIZE,
    parameter int unsigned PAGE_NUM      = DFLT_PAGE_NUM,
    parameter int unsigned ADDR_BITWIDTH = DFLT_ADDR_BITWIDTH
) (
    input  logic                     write_clk,
    input  logic                     rstn,
    input  logic                     load_req_i,
    input  logic                     load_abort_i,
    input  logic                     s_valid_i,
    input  logic [QUAN_SIZE-1:0]     s_data_i,
    output logic                     s_ready_o,
    input  logic                     swap_req_i,
    output logic                     swap_ack_o,
    output logic                     swap_stall_o,
    output logic [1:0]               lut_we_o,
    output logic [ADDR_BITWIDTH-1:0] lut_waddr_o,
    output logic [QUAN_SIZE-1:0]     lut_wdata_o,
    output logic                     rd_bank_sel_o,
    output logic                     busy_o,
    output logic                     shadow_vld_o
);

    // One extra bit so PAGE_NUM == 2**ADDR_BITWIDTH fits without wrapping.
    localparam int unsigned CNT_W = ADDR_BITWIDTH + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_bank_sel_q, rd_bank_sel_d;
    logic             shadow_vld_q, shadow_vld_d;
    logic             swap_ack_q, swap_ack_d;
    logic             beat_acc, last_beat, do_swap, wr_pending;

    assign wr_pending = |lut_we_o;
    assign beat_acc   = (state_q == ST_LOAD) && s_valid_i && !load_abort_i;
    assign last_beat  = beat_acc && (cnt_q == CNT_W'(PAGE_NUM - 1));
    // Swap waits for the final write to retire so the new active bank is whole.
    assign do_swap    = (state_q == ST_READY) && swap_req_i && shadow_vld_q
                        && !wr_pending && !load_abort_i;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (load_req_i) state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_abort_i)   state_d = ST_IDLE;
                else if (last_beat) state_d = ST_READY;
            end
            ST_READY: if (load_abort_i || do_swap) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready_o    = 1'b0;
        busy_o       = 1'b0;
        swap_stall_o = 1'b0;
        s_ready_o    = (state_q == ST_LOAD);
        busy_o       = (state_q != ST_IDLE);
        swap_stall_o = swap_req_i && !((state_q == ST_READY) && shadow_vld_q);
    end

    always_comb begin
        cnt_d         = cnt_q;
        rd_bank_sel_d = rd_bank_sel_q;
        shadow_vld_d  = shadow_vld_q;
        swap_ack_d    = 1'b0;
        if ((state_q == ST_IDLE) && load_req_i) begin
            cnt_d        = '0;
            shadow_vld_d = 1'b0;
        end
        if (beat_acc)  cnt_d = cnt_q + CNT_W'(1);
        if (last_beat) shadow_vld_d = 1'b1;
        if (load_abort_i && (state_q != ST_IDLE)) shadow_vld_d = 1'b0;
        if (do_swap) begin
            rd_bank_sel_d = ~rd_bank_sel_q;
            swap_ack_d    = 1'b1;
            shadow_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q         <= '0;
            rd_bank_sel_q <= 1'b0;
            shadow_vld_q  <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rd_bank_sel_q <= rd_bank_sel_d;
            shadow_vld_q  <= shadow_vld_d;
            swap_ack_q    <= swap_ack_d;
        end
    end

    ib_lut_wr_stage #(
        .QUAN_SIZE     (QUAN_SIZE),
        .ADDR_BITWIDTH (ADDR_BITWIDTH)
    ) u_wr_stage (
        .clk        (write_clk),
        .rst_n      (rstn),
        .wr_valid_i (beat_acc),
        .wr_bank_i  (~rd_bank_sel_q),
        .wr_addr_i  (cnt_q[ADDR_BITWIDTH-1:0]),
        .wr_data_i  (s_data_i),
        .flush_i    (load_abort_i),
        .we_o       (lut_we_o),
        .waddr_o    (lut_waddr_o),
        .wdata_o    (lut_wdata_o)
    );

    assign swap_ack_o    = swap_ack_q;
    assign rd_bank_sel_o = rd_bank_sel_q;
    assign shadow_vld_o  = shadow_vld_q;

endmodule
